// File: rtl/speed_sched_pkg.sv
// Shared types and helpers for the game-speed scheduler.
// Holds the state encoding, the divider width and the level-to-period mapping.
package speed_sched_pkg;

  localparam int CNT_W = 27;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_CRASH = 2'd3
  } state_t;

  // Decrement is compared against base before subtracting so the result never underflows.
  function automatic logic [CNT_W-1:0] clamp_period(
    input logic [2:0]       lvl,
    input logic [CNT_W-1:0] base,
    input logic [CNT_W-1:0] step,
    input logic [CNT_W-1:0] min_p
  );
    logic [CNT_W-1:0] dec;
    dec = CNT_W'(lvl) * step;
    if (dec >= base) begin
      return min_p;
    end else if ((base - dec) < min_p) begin
      return min_p;
    end else begin
      return base - dec;
    end
  endfunction

endpackage

// File: rtl/speed_tick_sched_tick_divider.sv
// Programmable divider: counts z up to period_q-1, emits a registered tick after each wrap
// and a registered square wave that is high for the first half of each period.
module tick_divider
  import speed_sched_pkg::*;
#(
  parameter logic [CNT_W-1:0] INIT_PERIOD = 27'd360000
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             y
);

  logic [CNT_W-1:0] z;
  logic [CNT_W-1:0] period_q;
  logic             wrap;

  assign wrap = (z == period_q - CNT_W'(1));

  // A new period is only taken at a wrap or a clear, so a running period is never cut short.
  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      z        <= '0;
      period_q <= INIT_PERIOD;
      tick     <= 1'b0;
      y        <= 1'b0;
    end else if (clear) begin
      z        <= '0;
      period_q <= period;
      tick     <= 1'b0;
      y        <= 1'b0;
    end else if (enable) begin
      tick <= wrap;
      y    <= (z < (period_q >> 1));
      if (wrap) begin
        z        <= '0;
        period_q <= period;
      end else begin
        z <= z + CNT_W'(1);
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/speed_tick_sched.sv
// Game-speed scheduler: sequences the tick divider through idle/run/pause/crash-hold
// and speeds the game up by one level every LEVEL_TICKS ticks spent running.
module speed_tick_sched
  import speed_sched_pkg::*;
#(
  parameter logic [CNT_W-1:0] BASE_PERIOD = 27'd360000,
  parameter logic [CNT_W-1:0] STEP        = 27'd30000,
  parameter logic [CNT_W-1:0] MIN_PERIOD  = 27'd60000,
  parameter int               LEVEL_TICKS = 64,
  parameter int               MAX_LEVEL   = 7,
  parameter int               HOLD_TICKS  = 32
) (
  input  logic       clock_in,
  input  logic       reset,
  input  logic       start,
  input  logic       pause,
  input  logic       crash,
  output logic       tick,
  output logic       y,
  output logic [2:0] level,
  output logic       running,
  output logic [1:0] state
);

  localparam int TW = $clog2(LEVEL_TICKS + 1);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  state_t           state_q;
  state_t           state_d;
  logic             running_q;
  logic [2:0]       level_q;
  logic [2:0]       level_ahead;
  logic [TW-1:0]    tick_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             level_wrap;
  logic             hold_done;
  logic             div_tick;
  logic             div_y;
  logic             div_enable;
  logic             div_clear;
  logic [CNT_W-1:0] div_period;

  assign level_wrap = (tick_cnt == TW'(LEVEL_TICKS - 1));
  assign hold_done  = (state_q == S_CRASH) && div_tick && (hold_cnt == HW'(HOLD_TICKS - 1));

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == S_RUN);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (crash) state_d = S_CRASH;
               else if (pause) state_d = S_PAUSE;
      S_PAUSE: if (crash) state_d = S_CRASH;
               else if (!pause) state_d = S_RUN;
      S_CRASH: if (hold_done) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // The period handed to the divider anticipates the level step so the new speed
  // takes effect on the period right after the advancing wrap.
  always_comb begin
    div_enable = (state_q == S_RUN) || (state_q == S_CRASH);
    div_clear  = 1'b0;
    case (state_q)
      S_IDLE:          div_clear = start;
      S_RUN, S_PAUSE:  div_clear = crash;
      S_CRASH:         div_clear = hold_done;
      default:         div_clear = 1'b0;
    endcase
    level_ahead = level_q;
    if (level_wrap && (level_q != 3'(MAX_LEVEL))) begin
      level_ahead = level_q + 3'd1;
    end
    div_period = BASE_PERIOD;
    if (((state_q == S_RUN) || (state_q == S_PAUSE)) && !crash) begin
      div_period = clamp_period(level_ahead, BASE_PERIOD, STEP, MIN_PERIOD);
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      level_q  <= '0;
      tick_cnt <= '0;
    end else if (((state_q == S_IDLE) && start) || hold_done) begin
      level_q  <= '0;
      tick_cnt <= '0;
    end else if (div_tick && (state_q != S_CRASH)) begin
      if (level_wrap) begin
        tick_cnt <= '0;
        level_q  <= level_ahead;
      end else begin
        tick_cnt <= tick_cnt + TW'(1);
      end
    end
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
    end else if ((state_q != S_CRASH) || hold_done) begin
      hold_cnt <= '0;
    end else if (div_tick) begin
      hold_cnt <= hold_cnt + HW'(1);
    end
  end

  tick_divider #(
    .INIT_PERIOD(BASE_PERIOD)
  ) u_div (
    .clock_in(clock_in),
    .reset   (reset),
    .enable  (div_enable),
    .clear   (div_clear),
    .period  (div_period),
    .tick    (div_tick),
    .y       (div_y)
  );

  // The divider keeps running during crash-hold only to time the hold; none of it is shown.
  assign tick    = div_tick && (state_q != S_CRASH);
  assign y       = div_y && (state_q != S_CRASH);
  assign level   = level_q;
  assign running = running_q;
  assign state   = state_q;

endmodule
